// File: rtl/mem_stage_lsu_if.sv
// mem_stage_lsu_if: data-memory request/ready bus between the memory stage and data memory.
`default_nettype none

interface mem_stage_lsu_if #(
  parameter int XLEN = 32
);
  logic              dmem_req;
  logic              dmem_we;
  logic [XLEN-1:0]   dmem_addr;
  logic [XLEN-1:0]   dmem_wdata;
  logic [XLEN/8-1:0] dmem_be;
  logic              dmem_ready;
  logic [XLEN-1:0]   dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_ready, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_ready, dmem_rdata
  );
endinterface

`default_nettype wire

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: memory-stage load/store unit between EX/MEM and MEM/WB; stalls upstream
// while a data-memory access waits for ready. Rev 1.0
`default_nettype none

module mem_stage_lsu #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  wire logic                  clk,
  input  wire logic                  reset_n,
  input  wire logic                  valid_m,
  input  wire logic [XLEN-1:0]       alu_result_m,
  input  wire logic [XLEN-1:0]       write_data_m,
  input  wire logic [REG_ADDR_W-1:0] rd_m,
  input  wire logic [XLEN-1:0]       pc_plus_4_m,
  input  wire logic                  mem_read_m,
  input  wire logic                  mem_write_m,
  input  wire logic [2:0]            funct3_m,
  input  wire logic                  reg_write_m,
  input  wire logic [1:0]            result_src_m,
  mem_stage_lsu_if.master            dmem,
  output logic                       stall_m,
  output logic                       valid_w,
  output logic                       reg_write_w,
  output logic [1:0]                 result_src_w,
  output logic [REG_ADDR_W-1:0]      rd_w,
  output logic [XLEN-1:0]            alu_result_w,
  output logic [XLEN-1:0]            pc_plus_4_w,
  output logic [XLEN-1:0]            read_data_w,
  output logic                       lsu_fault_w
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t r_state;

  logic [1:0]      w_size;
  logic            w_unsigned;
  logic [1:0]      w_off;
  logic            w_mem_op;
  logic            w_f3_illegal;
  logic            w_misalign;
  logic            w_fault;
  logic            w_req;
  logic            w_stall;
  logic [3:0]      w_be;
  logic [XLEN-1:0] w_wdata;
  logic [XLEN-1:0] w_lane;
  logic [XLEN-1:0] w_load;
  logic            w_is_load;

  assign w_size     = funct3_m[1:0];
  assign w_unsigned = funct3_m[2];
  assign w_off      = alu_result_m[1:0];
  assign w_mem_op   = valid_m & (mem_read_m | mem_write_m);

  // Legal encodings are 000/001/010/100/101; anything with size 11 or unsigned word is illegal.
  assign w_f3_illegal = (w_size == 2'b11) | (funct3_m[2] & funct3_m[1]);
  assign w_misalign   = ((w_size == 2'b01) & w_off[0]) |
                        ((w_size == 2'b10) & (w_off != 2'b00));
  assign w_fault      = w_mem_op & (w_f3_illegal | w_misalign);

  // Gating with reset_n makes the request drop the instant reset asserts, even mid-WAIT.
  assign w_req   = reset_n & ((r_state == S_WAIT) | (w_mem_op & ~w_fault));
  assign w_stall = w_req & ~dmem.dmem_ready;
  assign stall_m = w_stall;

  always_comb begin
    w_be    = 4'hF;
    w_wdata = write_data_m;
    case (w_size)
      2'b00: begin
        w_be    = 4'b0001 << w_off;
        w_wdata = {4{write_data_m[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << w_off;
        w_wdata = {2{write_data_m[15:0]}};
      end
      default: begin
        w_be    = 4'hF;
        w_wdata = write_data_m;
      end
    endcase
  end

  assign dmem.dmem_req   = w_req;
  assign dmem.dmem_we    = w_req & mem_write_m;
  assign dmem.dmem_addr  = w_req ? {alu_result_m[XLEN-1:2], 2'b00} : '0;
  assign dmem.dmem_wdata = (w_req & mem_write_m) ? w_wdata : '0;
  assign dmem.dmem_be    = w_req ? w_be : '0;

  assign w_lane    = dmem.dmem_rdata >> {w_off, 3'b000};
  assign w_is_load = w_mem_op & mem_read_m & ~w_fault;

  always_comb begin
    w_load = w_lane;
    case (w_size)
      2'b00:   w_load = {{(XLEN-8){~w_unsigned & w_lane[7]}}, w_lane[7:0]};
      2'b01:   w_load = {{(XLEN-16){~w_unsigned & w_lane[15]}}, w_lane[15:0]};
      default: w_load = w_lane;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      valid_w      <= 1'b0;
      reg_write_w  <= 1'b0;
      result_src_w <= '0;
      rd_w         <= '0;
      alu_result_w <= '0;
      pc_plus_4_w  <= '0;
      read_data_w  <= '0;
      lsu_fault_w  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE:  if (w_stall) r_state <= S_WAIT;
        S_WAIT:  if (dmem.dmem_ready) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase

      if (w_stall) begin
        valid_w     <= 1'b0;
        reg_write_w <= 1'b0;
        lsu_fault_w <= 1'b0;
      end else begin
        valid_w      <= valid_m;
        reg_write_w  <= reg_write_m & valid_m & ~w_fault;
        result_src_w <= result_src_m;
        rd_w         <= rd_m;
        alu_result_w <= alu_result_m;
        pc_plus_4_w  <= pc_plus_4_m;
        read_data_w  <= w_is_load ? w_load : '0;
        lsu_fault_w  <= w_fault;
      end
    end
  end

endmodule

`default_nettype wire
